// File: rtl/teller_dispatcher.sv
// teller_dispatcher: round-robin scheduler that hands the head-of-queue
// customer to one of up to three tellers, pulses downSignal once per
// dispatch and counts customers served.
// Optional feature macro: ACK_TIMEOUT_EN (per-teller ready-drop timeout that
// force-clears a stuck busy bit and raises the sticky ackError flag).
module teller_dispatcher #(
   parameter int NT          = 3,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [NT-1:0] tellerReady,
   input  logic [1:0]    Tcount,
   input  logic          emptyFlag,
   output logic          downSignal,
   output logic [NT-1:0] grant,
   output logic [NT-1:0] busy,
   output logic [7:0]    servedCount,
   output logic          cfgError,
   output logic          ackError
);

   typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_t;

   state_t        state;
   state_t        state_next;
   logic [NT-1:0] mask;
   logic [NT-1:0] eligible;
   logic [NT-1:0] busy_next;
   logic [1:0]    rr_ptr;
   logic [1:0]    winner;
   logic [1:0]    pick;
   logic [1:0]    idx;
   logic          pick_valid;

   // Thermometer enable mask from the number of active tellers.
   always_comb begin
      mask = '0;
      case (Tcount)
         2'd1:    mask = 3'b001;
         2'd2:    mask = 3'b011;
         2'd3:    mask = 3'b111;
         default: mask = 3'b000;
      endcase
   end

   assign cfgError = (Tcount == 2'd0);
   assign eligible = tellerReady & ~busy & mask;

   // Round-robin pick: first eligible teller at or after rr_ptr, wrapping.
   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      idx        = '0;
      for (int k = 0; k < NT; k++) begin
         idx = 2'((int'(rr_ptr) + k) % NT);
         if (!pick_valid && eligible[idx]) begin
            pick_valid = 1'b1;
            pick       = idx;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // FSM next state and the one-cycle dispatch outputs.
   always_comb begin
      state_next = state;
      grant      = '0;
      downSignal = 1'b0;
      case (state)
         IDLE: begin
            // The dispatch decision is only ever taken here; emptyFlag
            // changing later does not abort a dispatch in flight.
            if (pick_valid && !emptyFlag) state_next = GRANT;
         end
         GRANT: begin
            grant      = {{(NT-1){1'b0}}, 1'b1} << winner;
            downSignal = 1'b1;
            state_next = SETTLE;
         end
         SETTLE: begin
            // Dead cycle so the queue counter and emptyFlag can settle.
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Latch the winner at the decision; advance pointer and count on dispatch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         winner      <= '0;
         rr_ptr      <= '0;
         servedCount <= '0;
      end else begin
         if (state == IDLE && state_next == GRANT) winner <= pick;
         if (state == GRANT) begin
            servedCount <= servedCount + 8'd1;
            rr_ptr      <= (winner == 2'(NT-1)) ? 2'd0 : winner + 2'd1;
         end
      end
   end

`ifdef ACK_TIMEOUT_EN
   logic [3:0]    timer [NT];
   logic [NT-1:0] timeout;

   // A teller is stuck if it keeps ready high for ACK_TIMEOUT busy cycles.
   always_comb begin
      timeout = '0;
      for (int i = 0; i < NT; i++)
         timeout[i] = busy[i] && tellerReady[i] && (timer[i] == 4'(ACK_TIMEOUT-1));
   end

   // Per-teller busy-age timers and the sticky timeout flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NT; i++) timer[i] <= '0;
         ackError <= 1'b0;
      end else begin
         for (int i = 0; i < NT; i++) begin
            if (grant[i] || !busy[i] || timeout[i]) timer[i] <= '0;
            else                                     timer[i] <= timer[i] + 4'd1;
         end
         if (|timeout) ackError <= 1'b1;
      end
   end

   assign busy_next = grant | (busy & tellerReady & ~timeout);
`else
   logic unused_ack_timeout;
   assign unused_ack_timeout = (ACK_TIMEOUT != 0);
   assign ackError           = 1'b0;
   assign busy_next          = grant | (busy & tellerReady);
`endif

   // Busy set on grant; cleared once the teller's ready line is seen low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) busy <= '0;
      else        busy <= busy_next;
   end

endmodule

// File: doc/teller_dispatcher.md
Name: teller_dispatcher

Overview:
- Sequential scheduler between the queue unit (people counter + wait-time ROM) and up to 3 tellers.
- Arbitrates round-robin among tellers signalling "ready for next customer" and hands the head-of-queue customer to one teller at a time.
- Emits the one-cycle downSignal pulse that decrements the queue counter; never dispatches from an empty queue.
- Tracks the total customers served.

Parameters:
- NT, 3, number of teller request lines; fixed at 3 to match the 2-bit Tcount encoding.
- ACK_TIMEOUT, 15, cycles a granted teller has to drop its ready line; used only with ACK_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- tellerReady  input  3  level; bit i high = teller i free and requesting a customer.
- Tcount  input  2  number of active tellers (1..3); 0 = none active.
- emptyFlag  input  1  queue-empty flag from the queue unit.
- downSignal  output  1  one-cycle pulse to the queue counter (front sensor equivalent).
- grant  output  3  one-hot, one-cycle; teller receiving the customer.
- busy  output  3  teller granted and not yet re-armed.
- servedCount  output  8  total customers dispatched since reset, wraps 255->0.
- cfgError  output  1  high while Tcount == 0.
- ackError  output  1  sticky timeout flag; tied 0 without ACK_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; downSignal=0, grant=0, busy=0, servedCount=0, ackError=0, rrPtr=0. cfgError stays combinational.
- Enable mask from Tcount:
  - 0 -> 000; 1 -> 001; 2 -> 011; 3 -> 111.
  - cfgError = (Tcount==0).
- Eligibility: eligible = tellerReady & ~busy & mask.
- FSM states: IDLE, GRANT, SETTLE.
- IDLE -> GRANT when eligible != 0 and emptyFlag == 0.
  - Winner is the first eligible bit at or after rrPtr, scanning upward and wrapping 2->0.
  - Winner is registered at this transition.
- GRANT (exactly 1 cycle):
  - grant = onehot(winner), downSignal = 1.
  - busy[winner] set; servedCount += 1; rrPtr = winner+1 mod 3.
  - -> SETTLE.
- SETTLE (exactly 1 cycle): outputs low; lets the counter and emptyFlag update. -> IDLE.
- Latency: eligible request to grant/downSignal = 1 cycle. Minimum spacing between dispatches = 3 cycles.
- busy[i] clears on the cycle after tellerReady[i] is sampled low. A teller must drop and re-raise ready to receive another customer.
- Empty queue: no grant and no downSignal ever. Requests wait in IDLE.
- emptyFlag rising during GRANT: the dispatch still completes. The decision is made in IDLE only.
- Tcount change: the mask applies only to new eligibility decisions. Existing busy bits are kept until their ready line drops.
- A disabled teller never receives a grant.
- Simultaneous requests: exactly one grant per dispatch. The others are served in round-robin order on later dispatches.
- cfgError is informational; with mask=000 no dispatch occurs.

Optional Feature:
- Macro: ACK_TIMEOUT_EN.
- Defined:
  - A per-teller 4-bit counter starts at grant.
  - If tellerReady[i] is still high after ACK_TIMEOUT cycles of busy, busy[i] is force-cleared and ackError is set.
  - ackError clears only on reset.
- Undefined: no timers; busy clears only on a ready drop; ackError tied 0.

Test Plan:
- Reset, Tcount=3, emptyFlag=0, tellerReady=001 -> 1 cycle later grant=001, downSignal=1 for exactly 1 cycle; busy=001; servedCount=1.
- tellerReady=111 held, then toggled low/high after each grant, queue nonempty -> grants in order 001, 010, 100, 001; downSignal pulses 3 cycles apart.
- emptyFlag=1, tellerReady=111 for 20 cycles -> grant=000, downSignal never asserted, servedCount unchanged.
- Tcount=1, tellerReady=110 -> no grant. Set Tcount=0 -> cfgError=1.
- Assert reset low during GRANT -> all outputs 0 immediately (asynchronously); FSM in IDLE after release.
- ACK_TIMEOUT_EN defined: teller 0 granted, holds ready high 16 cycles -> busy[0]=0, ackError=1 until reset.
- 256 dispatches -> servedCount wraps to 0.
